wb_epb_master: RTL and testbench
================================

WB_EPB_MASTER -- requirements
Module: wb_epb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 10: width of the EPB wait counter; the timeout is 2^TIMEOUT_W-1 cycles in STROBE.
REQ-002 SHALL have ports: wb_clk_i  in  1  sole clock for the WB and EPB sides.
REQ-003 SHALL have ports: wb_rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WB slave cycle, strobe and write-enable.
REQ-005 SHALL have ports: wb_sel_i  in  2  byte selects; wb_adr_i  in  32  byte address; wb_dat_i  in  16  write data.
REQ-006 SHALL have ports: wb_dat_o  out  16  read data; wb_ack_o, wb_err_o  out  1 each  completion pulses.
REQ-007 SHALL have ports: epb_cs_n, epb_r_w_n  out  1 each; epb_be_n  out  2; epb_addr  out  23; epb_addr_gp  out  6.
REQ-008 SHALL have ports: epb_data_o  out  16; epb_data_oe  out  1  master drive enable; epb_data_i  in  16; epb_rdy  in  1  target ready pulse.

Function
REQ-009 SHALL run the FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE, one state per wb_clk_i cycle except STROBE.
REQ-010 IDLE: on wb_cyc_i & wb_stb_i SHALL register the address, sel, we and write data, and go to SETUP.
REQ-011 SHALL map the registered address as epb_addr = adr[23:1] and epb_addr_gp = adr[29:24]; adr[31:30] and adr[0] are ignored.
REQ-012 SHALL drive epb_be_n = ~sel and epb_r_w_n = ~we from SETUP through DONE.
REQ-013 SHALL still run an EPB cycle when sel = 00, with epb_be_n = 11.
REQ-014 SETUP: address valid and epb_cs_n = 1 for exactly one cycle; then STROBE.
REQ-015 STROBE: epb_cs_n = 0; each cycle the wait counter increments from 0; epb_rdy = 1 moves to DONE with result ack.
REQ-016 Read: on the cycle epb_rdy is sampled high, SHALL capture epb_data_i into wb_dat_o; wb_dat_o holds until the next read capture.
REQ-017 Write: epb_data_oe = 1 and epb_data_o = registered data from SETUP through DONE; on reads epb_data_oe = 0 throughout.
REQ-018 DONE: epb_cs_n = 1; SHALL pulse wb_ack_o or wb_err_o for exactly one cycle, then return to IDLE.
REQ-019 Ack latency: wb_ack_o SHALL go high in the cycle after epb_rdy is sampled.
REQ-020 epb_cs_n SHALL be high for at least 2 cycles between STROBE phases (DONE, then SETUP), so the target always sees a falling edge.
REQ-021 SHALL ignore epb_rdy in IDLE, SETUP and DONE.
REQ-022 If wb_cyc_i is low on entry to DONE, SHALL finish the EPB cycle but suppress both the ack and err pulses.
REQ-023 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-024 On wb_rst_i = 1, asynchronously: state IDLE, epb_cs_n = 1, epb_r_w_n = 1, epb_be_n = 11.
REQ-025 On wb_rst_i = 1, asynchronously: epb_addr = 0, epb_addr_gp = 0, epb_data_o = 0, epb_data_oe = 0.
REQ-026 On wb_rst_i = 1, asynchronously: wb_dat_o = 0, wb_ack_o = 0, wb_err_o = 0, counter = 0.
REQ-027 Reset mid-transaction SHALL abort the cycle with no ack/err, and epb_cs_n SHALL return high immediately.

Configuration
REQ-028 With WB_EPB_MASTER_TIMEOUT_EN defined: when the counter reaches 2^TIMEOUT_W-1 without epb_rdy, go to DONE with result err.
REQ-029 With WB_EPB_MASTER_TIMEOUT_EN defined: wb_dat_o is unchanged on timeout, and epb_rdy on the terminal-count cycle wins (ack, no err).
REQ-030 Without WB_EPB_MASTER_TIMEOUT_EN: STROBE waits indefinitely for epb_rdy, wb_err_o is tied 0, and the counter is not built.

Structure
REQ-031 Package wb_epb_pkg SHALL hold the FSM state encoding, the address field positions (23/6-bit, offsets 1/24) and the TIMEOUT_W default.
REQ-032 The wait counter with terminal-count flag SHALL be sub-module wb_epb_timeout; instantiate it only under WB_EPB_MASTER_TIMEOUT_EN.

Verification
REQ-033 Write test: adr = 0x0100_0ABC, dat = 0x1234, sel = 11, rdy after 3 STROBE cycles -> epb_addr = 0x00055E, epb_addr_gp = 0x01, data_oe = 1, one ack, cs_n low 3 cycles.
REQ-034 Read test: adr = 0x0000_0010, epb_data_i = 0xBEEF with rdy -> epb_addr = 0x000008, data_oe = 0, next-cycle ack, wb_dat_o = 0xBEEF.
REQ-035 Back-to-back test: two writes with stb reasserted right after ack -> cs_n high >= 2 cycles between the low phases, two acks, no lost cycle.
REQ-036 Timeout test (macro on, TIMEOUT_W = 4): no rdy -> err pulse 15 cycles after cs_n falls, no ack, wb_dat_o unchanged.
REQ-037 Timeout boundary test (TIMEOUT_W = 4): rdy on the terminal-count cycle -> ack only.
REQ-038 Robustness test: reset asserted in STROBE -> cs_n = 1 asynchronously, no ack/err; spurious rdy in IDLE -> no response.
REQ-039 Cycle-drop test: cyc dropped during STROBE -> EPB cycle completes, no ack/err.

Source files
------------

// File: rtl/wb_epb_pkg.sv
// Shared definitions for the Wishbone-to-EPB bridge: FSM encoding,
// EPB address field placement and the default wait-counter width.
package wb_epb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } epb_state_t;

    // EPB address bus: 23-bit halfword address taken from WB byte address bit 1
    localparam int EPB_ADDR_W   = 23;
    localparam int EPB_ADDR_LSB = 1;

    // EPB general-purpose address bits taken from WB address bit 24
    localparam int EPB_GP_W     = 6;
    localparam int EPB_GP_LSB   = 24;

    // Default width of the STROBE wait counter
    localparam int TIMEOUT_W_DEF = 10;

endpackage

// File: rtl/wb_epb_timeout.sv
// STROBE wait counter. Counts while en is high and clears to zero whenever en
// drops, so every STROBE phase starts counting from 0. tc flags the cycle on
// which the counter steps onto its all-ones value (2^TIMEOUT_W-1 cycles).
module wb_epb_timeout #(
    parameter int TIMEOUT_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);

    localparam logic [TIMEOUT_W-1:0] TC_VAL = ~(TIMEOUT_W'(1));

    logic [TIMEOUT_W-1:0] cnt;

    // Count STROBE cycles; restart from zero outside STROBE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/wb_epb_master.sv
// Wishbone slave to EPB master bridge. One WB access becomes one EPB cycle:
// IDLE -> SETUP (address out, cs_n high) -> STROBE (cs_n low, wait for rdy)
// -> DONE (cs_n high, ack/err pulse) -> IDLE.
// Optional feature: define WB_EPB_MASTER_TIMEOUT_EN to abort STROBE with an
// error after 2^TIMEOUT_W-1 cycles without epb_rdy.
module wb_epb_master
    import wb_epb_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [15:0]           wb_dat_i,
    output logic [15:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  epb_cs_n,
    output logic                  epb_r_w_n,
    output logic [1:0]            epb_be_n,
    output logic [EPB_ADDR_W-1:0] epb_addr,
    output logic [EPB_GP_W-1:0]   epb_addr_gp,
    output logic [15:0]           epb_data_o,
    output logic                  epb_data_oe,
    input  logic [15:0]           epb_data_i,
    input  logic                  epb_rdy
);

    epb_state_t state_q, state_d;
    logic       we_q;
    logic       capture;
    logic       rdy_hit;
    logic       timeout_hit;

    // Address bits outside the EPB fields carry no meaning on this bus
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:30], wb_adr_i[0]};

`ifdef WB_EPB_MASTER_TIMEOUT_EN
    logic tc;

    wb_epb_timeout #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .en  (state_q == ST_STROBE),
        .tc  (tc)
    );

    // rdy on the terminal-count cycle takes priority over the timeout
    assign timeout_hit = (state_q == ST_STROBE) && !epb_rdy && tc;
`else
    localparam int unused_timeout_w = TIMEOUT_W;
    assign timeout_hit = 1'b0;
`endif

    assign capture = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign rdy_hit = (state_q == ST_STROBE) && epb_rdy;

    // Chip select is purely a function of state so reset releases it at once
    assign epb_cs_n    = (state_q != ST_STROBE);
    assign epb_r_w_n   = ~we_q;
    assign epb_data_oe = we_q && (state_q != ST_IDLE);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rdy is only looked at while in STROBE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (capture) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (rdy_hit || timeout_hit) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch the WB request; it stays on the EPB pins until the next request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q        <= 1'b0;
            epb_be_n    <= 2'b11;
            epb_addr    <= '0;
            epb_addr_gp <= '0;
            epb_data_o  <= '0;
        end else if (capture) begin
            we_q        <= wb_we_i;
            epb_be_n    <= ~wb_sel_i;
            epb_addr    <= wb_adr_i[EPB_ADDR_LSB +: EPB_ADDR_W];
            epb_addr_gp <= wb_adr_i[EPB_GP_LSB +: EPB_GP_W];
            epb_data_o  <= wb_dat_i;
        end
    end

    // Ack pulse during DONE (suppressed if the master has abandoned the cycle)
    // and read-data capture on the rdy cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= rdy_hit && wb_cyc_i;
            if (rdy_hit && !we_q) begin
                wb_dat_o <= epb_data_i;
            end
        end
    end

`ifdef WB_EPB_MASTER_TIMEOUT_EN
    // Error pulse during DONE when STROBE ran out of time
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_err_o <= 1'b0;
        end else begin
            wb_err_o <= timeout_hit && wb_cyc_i;
        end
    end
`else
    assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_epb_master.sv
// Directed testbench for wb_epb_master (TIMEOUT_W = 4).
module tb_wb_epb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [1:0]  sel;
    logic [31:0] adr;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic        ack, err;
    logic        cs_n, r_w_n;
    logic [1:0]  be_n;
    logic [22:0] eaddr;
    logic [5:0]  egp;
    logic [15:0] edata_o;
    logic        edata_oe;
    logic [15:0] edata_i;
    logic        rdy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_epb_master #(.TIMEOUT_W(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_adr_i    (adr),
        .wb_dat_i    (dat_w),
        .wb_dat_o    (dat_r),
        .wb_ack_o    (ack),
        .wb_err_o    (err),
        .epb_cs_n    (cs_n),
        .epb_r_w_n   (r_w_n),
        .epb_be_n    (be_n),
        .epb_addr    (eaddr),
        .epb_addr_gp (egp),
        .epb_data_o  (edata_o),
        .epb_data_oe (edata_oe),
        .epb_data_i  (edata_i),
        .epb_rdy     (rdy)
    );

    // observations of the last transfer
    int          o_low, o_pre, o_ack, o_err, o_both, o_oe_hi, o_oe_lo_low;
    bit          o_done, o_ack_rise, o_err_rise;
    logic [22:0] o_addr;
    logic [5:0]  o_gp;
    logic [1:0]  o_be;
    logic        o_rw;
    logic [15:0] o_dout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one WB access; rdy is raised during STROBE cycle number rdy_at
    // (0 = never). Observations land in the o_* variables.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, input int rdy_at,
                        input logic [15:0] rdata, input bit drop_cyc);
        int  tail;
        bit  seen_low, rose;
        tail = 0; seen_low = 0; rose = 0;
        o_low = 0; o_pre = 0; o_ack = 0; o_err = 0; o_both = 0;
        o_oe_hi = 0; o_oe_lo_low = 0; o_done = 0; o_ack_rise = 0; o_err_rise = 0;
        o_addr = '0; o_gp = '0; o_be = '0; o_rw = 1'b0; o_dout = '0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        edata_i = rdata;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (edata_oe) o_oe_hi++;
            if (ack) o_ack++;
            if (err) o_err++;
            if (ack && err) o_both++;
            if (!cs_n) begin
                o_low++;
                if (!seen_low) begin
                    o_addr = eaddr; o_gp = egp; o_be = be_n; o_rw = r_w_n; o_dout = edata_o;
                end
                seen_low = 1;
                if (!edata_oe) o_oe_lo_low++;
                if (drop_cyc && o_low == 1) begin
                    cyc = 1'b0; stb = 1'b0;
                end
                rdy = (o_low == rdy_at);
            end else begin
                rdy = 1'b0;
                if (!seen_low) begin
                    o_pre++;
                end else if (!rose) begin
                    rose = 1; o_ack_rise = ack; o_err_rise = err;
                end else begin
                    tail++;
                end
            end
            if (ack || err) begin
                cyc = 1'b0; stb = 1'b0;
            end
            if (rose && tail >= 2) begin
                o_done = 1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        edata_i = 0; rdy = 0;
        tick(); tick();
        if ({cs_n, r_w_n, be_n} !== 4'b1111) begin
            n_bad++; $display("FAIL rst_ctl got=%b want=1111", {cs_n, r_w_n, be_n});
        end
        n_cmp++;
        if ({eaddr, egp, edata_o, edata_oe} !== 46'h0) begin
            n_bad++; $display("FAIL rst_bus got=%h want=0", {eaddr, egp, edata_o, edata_oe});
        end
        n_cmp++;
        if ({dat_r, ack, err} !== 18'h0) begin
            n_bad++; $display("FAIL rst_wb got=%h want=0", {dat_r, ack, err});
        end
        n_cmp++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        xfer(1'b1, 32'h0100_0ABC, 16'h1234, 2'b11, 3, 16'h0000, 1'b0);
        if (o_done !== 1'b1) begin n_bad++; $display("FAIL wr_done got=%0d want=1", o_done); end
        n_cmp++;
        if (o_addr !== 23'h00055E) begin n_bad++; $display("FAIL wr_addr got=%h want=00055e", o_addr); end
        n_cmp++;
        if (o_gp !== 6'h01) begin n_bad++; $display("FAIL wr_gp got=%h want=01", o_gp); end
        n_cmp++;
        if ({o_be, o_rw} !== 3'b000) begin n_bad++; $display("FAIL wr_be_rw got=%b want=000", {o_be, o_rw}); end
        n_cmp++;
        if (o_dout !== 16'h1234) begin n_bad++; $display("FAIL wr_data got=%h want=1234", o_dout); end
        n_cmp++;
        if (o_pre != 1) begin n_bad++; $display("FAIL wr_setup got=%0d want=1", o_pre); end
        n_cmp++;
        if (o_low != 3) begin n_bad++; $display("FAIL wr_cs_low got=%0d want=3", o_low); end
        n_cmp++;
        if (o_ack != 1 || o_err != 0 || o_ack_rise !== 1'b1) begin
            n_bad++; $display("FAIL wr_ack got=%0d/%0d/%0d want=1/0/1", o_ack, o_err, o_ack_rise);
        end
        n_cmp++;
        if (o_oe_hi != 5 || o_oe_lo_low != 0) begin
            n_bad++; $display("FAIL wr_oe got=%0d/%0d want=5/0", o_oe_hi, o_oe_lo_low);
        end
        n_cmp++;
        if (dat_r !== 16'h0000) begin n_bad++; $display("FAIL wr_rdata got=%h want=0000", dat_r); end
        n_cmp++;
    endtask

    task automatic test_read();
        xfer(1'b0, 32'h0000_0010, 16'h0000, 2'b11, 1, 16'hBEEF, 1'b0);
        if ({o_addr, o_gp} !== {23'h000008, 6'h00}) begin
            n_bad++; $display("FAIL rd_addr got=%h want=000008/00", {o_addr, o_gp});
        end
        n_cmp++;
        if (o_rw !== 1'b1 || o_oe_hi != 0) begin
            n_bad++; $display("FAIL rd_dir got=%b/%0d want=1/0", o_rw, o_oe_hi);
        end
        n_cmp++;
        if (o_low != 1 || o_ack != 1 || o_ack_rise !== 1'b1) begin
            n_bad++; $display("FAIL rd_ack got=%0d/%0d/%0d want=1/1/1", o_low, o_ack, o_ack_rise);
        end
        n_cmp++;
        if (dat_r !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data got=%h want=beef", dat_r); end
        n_cmp++;
    endtask

    task automatic test_addr_sel_edges();
        xfer(1'b1, 32'hFFFF_FFFF, 16'hA5A5, 2'b00, 2, 16'h0000, 1'b0);
        if ({o_addr, o_gp} !== {23'h7FFFFF, 6'h3F}) begin
            n_bad++; $display("FAIL max_addr got=%h want=7fffff/3f", {o_addr, o_gp});
        end
        n_cmp++;
        if (o_be !== 2'b11 || o_low != 2 || o_ack != 1) begin
            n_bad++; $display("FAIL sel00 got=%b/%0d/%0d want=11/2/1", o_be, o_low, o_ack);
        end
        n_cmp++;
        xfer(1'b0, 32'hC000_0003, 16'h0000, 2'b01, 4, 16'h0F0F, 1'b0);
        if ({o_addr, o_gp, o_be} !== {23'h000001, 6'h00, 2'b10}) begin
            n_bad++; $display("FAIL sel01 got=%h want=000001/00/2", {o_addr, o_gp, o_be});
        end
        n_cmp++;
        if (dat_r !== 16'h0F0F || o_low != 4) begin
            n_bad++; $display("FAIL rd4 got=%h/%0d want=0f0f/4", dat_r, o_low);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int          lows, run, gap, min_gap, acks, errs, post;
        logic        prev_cs;
        logic [22:0] addr2;
        logic [15:0] data2;
        lows = 0; run = 0; gap = 0; min_gap = 99; acks = 0; errs = 0; post = 0;
        prev_cs = 1'b1; addr2 = '0; data2 = '0;
        cyc = 1; stb = 1; we = 1; sel = 2'b11; adr = 32'h0000_0200; dat_w = 16'h1111;
        for (int t = 0; t < 80; t++) begin
            tick();
            if (ack) acks++;
            if (err) errs++;
            if (!cs_n) begin
                if (prev_cs) begin
                    lows++;
                    if (lows > 1 && gap < min_gap) min_gap = gap;
                    if (lows == 2) begin addr2 = eaddr; data2 = edata_o; end
                    run = 0;
                end
                run++;
                rdy = (run == 2);
            end else begin
                rdy = 1'b0;
                gap = prev_cs ? gap + 1 : 1;
            end
            prev_cs = cs_n;
            if (ack) begin
                if (acks == 1) begin
                    adr = 32'h0000_0400; dat_w = 16'h2222;
                end else begin
                    cyc = 0; stb = 0;
                end
            end
            if (acks >= 2) post++;
            if (post >= 3) break;
        end
        cyc = 0; stb = 0; rdy = 0;
        if (lows != 2 || acks != 2 || errs != 0) begin
            n_bad++; $display("FAIL b2b_count got=%0d/%0d/%0d want=2/2/0", lows, acks, errs);
        end
        n_cmp++;
        if (min_gap < 2) begin n_bad++; $display("FAIL b2b_gap got=%0d want>=2", min_gap); end
        n_cmp++;
        if (addr2 !== 23'h000200 || data2 !== 16'h2222) begin
            n_bad++; $display("FAIL b2b_second got=%h/%h want=000200/2222", addr2, data2);
        end
        n_cmp++;
    endtask

    task automatic test_cycle_drop();
        xfer(1'b1, 32'h0000_0020, 16'h3333, 2'b11, 3, 16'h0000, 1'b1);
        if (o_done !== 1'b1 || o_low != 3) begin
            n_bad++; $display("FAIL drop_cycle got=%0d/%0d want=1/3", o_done, o_low);
        end
        n_cmp++;
        if (o_ack != 0 || o_err != 0) begin
            n_bad++; $display("FAIL drop_resp got=%0d/%0d want=0/0", o_ack, o_err);
        end
        n_cmp++;
        xfer(1'b0, 32'h0000_0040, 16'h0000, 2'b11, 2, 16'h5A5A, 1'b0);
        if (o_ack != 1 || dat_r !== 16'h5A5A) begin
            n_bad++; $display("FAIL drop_next got=%0d/%h want=1/5a5a", o_ack, dat_r);
        end
        n_cmp++;
    endtask

`ifdef WB_EPB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        xfer(1'b0, 32'h0000_0080, 16'h0000, 2'b11, 0, 16'hDEAD, 1'b0);
        if (o_low != 15 || o_err_rise !== 1'b1) begin
            n_bad++; $display("FAIL to_len got=%0d/%0d want=15/1", o_low, o_err_rise);
        end
        n_cmp++;
        if (o_err != 1 || o_ack != 0 || o_both != 0) begin
            n_bad++; $display("FAIL to_resp got=%0d/%0d/%0d want=1/0/0", o_err, o_ack, o_both);
        end
        n_cmp++;
        if (dat_r !== 16'h5A5A) begin n_bad++; $display("FAIL to_rdata got=%h want=5a5a", dat_r); end
        n_cmp++;
        xfer(1'b0, 32'h0000_0080, 16'h0000, 2'b11, 15, 16'hC0DE, 1'b0);
        if (o_low != 15 || o_ack != 1 || o_err != 0) begin
            n_bad++; $display("FAIL to_edge got=%0d/%0d/%0d want=15/1/0", o_low, o_ack, o_err);
        end
        n_cmp++;
        if (dat_r !== 16'hC0DE) begin n_bad++; $display("FAIL to_edge_data got=%h want=c0de", dat_r); end
        n_cmp++;
    endtask
`else
    task automatic test_long_wait();
        xfer(1'b0, 32'h0000_0080, 16'h0000, 2'b11, 20, 16'hC0DE, 1'b0);
        if (o_low != 20 || o_ack != 1 || o_err != 0) begin
            n_bad++; $display("FAIL long_wait got=%0d/%0d/%0d want=20/1/0", o_low, o_ack, o_err);
        end
        n_cmp++;
        if (dat_r !== 16'hC0DE) begin n_bad++; $display("FAIL long_data got=%h want=c0de", dat_r); end
        n_cmp++;
    endtask
`endif

    task automatic test_robust();
        int  lows, resp;
        bit  found;
        lows = 0; resp = 0; found = 0;
        cyc = 0; stb = 0; rdy = 1'b1; edata_i = 16'h1234;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (!cs_n) lows++;
            if (ack || err) resp++;
        end
        rdy = 1'b0;
        tick();
        if (lows != 0 || resp != 0 || dat_r !== 16'hC0DE) begin
            n_bad++; $display("FAIL idle_rdy got=%0d/%0d/%h want=0/0/c0de", lows, resp, dat_r);
        end
        n_cmp++;
        cyc = 1; stb = 1; we = 1; sel = 2'b01; adr = 32'h0000_0100; dat_w = 16'h7777;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (!cs_n) begin found = 1; break; end
        end
        if (!found) begin n_bad++; $display("FAIL rst_mid_reach got=0 want=1"); end
        n_cmp++;
        rst = 1'b1;
        #1;
        if ({cs_n, r_w_n, be_n, edata_oe} !== 5'b11110) begin
            n_bad++; $display("FAIL rst_async got=%b want=11110", {cs_n, r_w_n, be_n, edata_oe});
        end
        n_cmp++;
        if ({ack, err, dat_r} !== 18'h0) begin
            n_bad++; $display("FAIL rst_async_wb got=%h want=0", {ack, err, dat_r});
        end
        n_cmp++;
        cyc = 0; stb = 0;
        tick(); tick();
        rst = 1'b0;
        lows = 0; resp = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (!cs_n) lows++;
            if (ack || err) resp++;
        end
        if (lows != 0 || resp != 0) begin
            n_bad++; $display("FAIL rst_after got=%0d/%0d want=0/0", lows, resp);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_sel_edges();
        test_back_to_back();
        test_cycle_drop();
`ifdef WB_EPB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_robust();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
